// File: rtl/hp_sweep_ctrl.sv
// hp_sweep_ctrl: wishbone-programmed sweep sequencer for the hoggephase glitch detectors.
module hp_sweep_ctrl #(
   parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_data,
   input  logic        hp_alarm,
   output logic        hp_vcc_en,
   output logic        hp_glitch,
   output logic        hp_alarm_rst,
   output logic        hp_ctr_rst
);
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_SAMPLE} state_t;
   state_t      r_state;
   logic        r_ack, r_done, r_clr, r_vcc_en, r_glitch, r_rst, r_s1, r_s2, r_s3;
   logic [31:0] r_rdata;
   logic [15:0] r_win_len, r_gl_off, r_idx;
   logic [7:0]  r_num_win, r_cnt, r_walarm, r_max, r_wdone;
   logic        r_gl_en;
   logic        w_access, w_wr, w_start, w_abort, w_busy, w_edge, w_more, w_unused;
   logic [2:0]  w_reg;
   logic [15:0] w_len;
   logic [7:0]  w_cnt;
   logic [8:0]  w_wdone_nx;
   logic [31:0] w_rdata;
   assign w_access   = i_wb_cyc & i_wb_stb & (i_wb_addr[31:5] == BASE_ADDRESS[31:5]);
   assign w_wr       = w_access & i_wb_we;
   assign w_reg      = i_wb_addr[4:2];
   assign w_abort    = w_wr && w_reg == 3'd0 && i_wb_data[1];
   assign w_start    = w_wr && w_reg == 3'd0 && i_wb_data[0] && !i_wb_data[1];
   assign w_busy     = r_state != S_IDLE;
   assign w_len      = r_win_len == 16'd0 ? 16'd1 : r_win_len;
   assign w_edge     = r_s2 & ~r_s3;
   // an edge seen in SAMPLE still belongs to the window being closed
   assign w_cnt      = (w_edge && (r_state == S_RUN || r_state == S_SAMPLE) && r_cnt != 8'hff) ? r_cnt + 8'd1 : r_cnt;
   assign w_wdone_nx = {1'b0, r_wdone} + 9'd1;
   assign w_more     = w_wdone_nx < {1'b0, r_num_win};
   assign w_unused   = &{1'b0, i_wb_addr[1:0], i_wb_data[30:16]};
   always_comb begin
      w_rdata = w_reg == 3'd0 ? {27'd0, 1'b0, r_state, r_done, w_busy} :
                w_reg == 3'd1 ? {16'd0, r_win_len} :
                w_reg == 3'd2 ? {24'd0, r_num_win} :
                w_reg == 3'd3 ? {r_gl_en, 15'd0, r_gl_off} :
                w_reg == 3'd4 ? {8'd0, r_wdone, r_max, r_walarm} : 32'd0;
   end
   assign o_wb_ack     = r_ack;
   assign o_wb_stall   = 1'b0;
   assign o_wb_data    = r_rdata;
   assign hp_vcc_en    = r_vcc_en;
   assign hp_glitch    = r_glitch;
   assign hp_alarm_rst = r_rst;
   assign hp_ctr_rst   = r_rst;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ack     <= 1'b0;
         r_rdata   <= 32'd0;
         r_win_len <= 16'd16;
         r_num_win <= 8'd1;
         r_gl_off  <= 16'd0;
         r_gl_en   <= 1'b0;
      end else begin
         r_ack   <= w_access;
         r_rdata <= (w_access && !i_wb_we) ? w_rdata : 32'd0;
         if (w_wr && !w_busy && w_reg == 3'd1) r_win_len <= i_wb_data[15:0];
         if (w_wr && !w_busy && w_reg == 3'd2) r_num_win <= i_wb_data[7:0];
         if (w_wr && !w_busy && w_reg == 3'd3) {r_gl_en, r_gl_off} <= {i_wb_data[31], i_wb_data[15:0]};
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         {r_s1, r_s2, r_s3} <= 3'd0;
         {r_done, r_clr, r_vcc_en, r_glitch, r_rst} <= 5'd0;
         {r_cnt, r_walarm, r_max, r_wdone} <= 32'd0;
         r_idx    <= 16'd0;
      end else begin
         {r_s1, r_s2, r_s3} <= {hp_alarm, r_s1, r_s2};
         r_glitch <= 1'b0;
         if (w_abort) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_vcc_en <= 1'b0;
            r_rst    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: if (w_start) begin
                  {r_walarm, r_max, r_wdone} <= 24'd0;
                  r_done <= r_num_win == 8'd0;
                  if (r_num_win != 8'd0) begin
                     r_state  <= S_CLEAR;
                     r_clr    <= 1'b0;
                     r_vcc_en <= 1'b1;
                     r_rst    <= 1'b1;
                  end
               end
               S_CLEAR: begin
                  r_cnt <= 8'd0;
                  r_clr <= 1'b1;
                  if (r_clr) begin
                     r_state  <= S_RUN;
                     r_idx    <= 16'd0;
                     r_rst    <= 1'b0;
                     r_glitch <= r_gl_en && r_gl_off == 16'd0;
                  end
               end
               S_RUN: begin
                  r_cnt <= w_cnt;
                  if (r_idx == w_len - 16'd1) r_state <= S_SAMPLE;
                  else begin
                     r_idx    <= r_idx + 16'd1;
                     r_glitch <= r_gl_en && r_gl_off == r_idx + 16'd1;
                  end
               end
               default: begin
                  r_wdone  <= w_wdone_nx[7:0];
                  r_walarm <= r_walarm + {7'd0, w_cnt != 8'd0};
                  r_max    <= w_cnt > r_max ? w_cnt : r_max;
                  r_state  <= w_more ? S_CLEAR : S_IDLE;
                  r_clr    <= 1'b0;
                  r_rst    <= w_more;
                  r_vcc_en <= w_more;
                  r_done   <= !w_more;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hp_sweep_ctrl.sv
// tb_hp_sweep_ctrl: scoreboard bench; bus accesses queue expected read data, an ack monitor checks it.
module tb_hp_sweep_ctrl;
   localparam logic [31:0] B = 32'h3000_0100;
   logic        clk = 0, reset = 1, cyc = 0, stb = 0, we = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic        o_wb_ack, o_wb_stall, hp_vcc_en, hp_glitch, hp_alarm_rst, hp_ctr_rst;
   logic [31:0] o_wb_data;
   logic        r_man = 0, model_on = 0;
   logic [3:0]  m_sh = 0;
   wire         w_alarm = (hp_glitch & model_on) | m_sh[0] | r_man;
   int          n_pass = 0, n_tot = 0, n_acc = 0, n_ack = 0, g_cnt = 0, g_idx = 0, g_last = -1, vcc_hi = 0, n;
   logic [63:0] q[$];

   hp_sweep_ctrl dut (
      .clk(clk), .reset(reset), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall),
      .o_wb_data(o_wb_data), .hp_alarm(w_alarm), .hp_vcc_en(hp_vcc_en), .hp_glitch(hp_glitch),
      .hp_alarm_rst(hp_alarm_rst), .hp_ctr_rst(hp_ctr_rst)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // alarm model: each glitch pulse yields three alarm pulses (glitch cycle, +2, +4)
   always @(posedge clk) m_sh <= (hp_glitch && model_on) ? 4'b1010 : m_sh >> 1;

   always @(negedge clk) begin
      if (o_wb_ack) begin
         n_ack++;
         if (q.size() == 0) check("ack_without_access", 32'(q.size()), 32'd1);
         else begin
            logic [63:0] e;
            e = q.pop_front();
            check($sformatf("rd@%h", e[63:32]), o_wb_data, e[31:0]);
         end
      end
      if (hp_vcc_en) vcc_hi++;
      if (hp_ctr_rst) g_idx = 0;
      else begin
         if (hp_glitch) begin g_last = g_idx; g_cnt++; end
         g_idx++;
      end
   end

   task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = w; addr = a; wdata = d;
      q.push_back({a, w ? 32'h0 : e});
      n_acc++;
      @(posedge clk); #1;
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic wait_idle(input int lim, output int cnt);
      cnt = 0;
      @(negedge clk);
      while (hp_vcc_en && cnt < lim) begin cnt++; @(negedge clk); end
      check("idle_timeout", 32'(cnt < lim), 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 0;
      // reset values, unmapped offsets, out-of-block address
      check("stall", {31'd0, o_wb_stall}, 32'd0);
      check("vcc_rst", {31'd0, hp_vcc_en}, 32'd0);
      wb(0, B + 32'h00, 0, 32'h0);
      wb(0, B + 32'h04, 0, 32'h10);
      wb(0, B + 32'h08, 0, 32'h01);
      wb(0, B + 32'h0C, 0, 32'h0);
      wb(0, B + 32'h10, 0, 32'h0);
      wb(1, B + 32'h14, 32'hFFFF_FFFF, 0);
      wb(0, B + 32'h14, 0, 32'h0);
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 1; addr = B + 32'h24; wdata = 32'h5;
      @(posedge clk); #1;
      cyc = 0; stb = 0; we = 0;
      wb(0, B + 32'h08, 0, 32'h01);
      // three quiet windows of 8
      wb(1, B + 32'h04, 8, 0);
      wb(1, B + 32'h08, 3, 0);
      wb(1, B + 32'h00, 1, 0);
      n = 0;
      @(negedge clk);
      while (hp_vcc_en && n < 200) begin n++; @(negedge clk); end
      check("busy_cycles", n, 33);
      wb(0, B + 32'h10, 0, 32'h0003_0000);
      wb(0, B + 32'h00, 0, 32'h2);
      // glitch at index 4, three alarm edges per window
      model_on = 1;
      wb(1, B + 32'h04, 10, 0);
      wb(1, B + 32'h08, 2, 0);
      wb(1, B + 32'h0C, 32'h8000_0004, 0);
      g_cnt = 0;
      wb(1, B + 32'h00, 1, 0);
      wait_idle(200, n);
      wb(0, B + 32'h10, 0, 32'h0002_0302);
      check("glitch_count", g_cnt, 2);
      check("glitch_index", g_last, 4);
      model_on = 0;
      // count saturation
      wb(1, B + 32'h0C, 0, 0);
      wb(1, B + 32'h04, 1000, 0);
      wb(1, B + 32'h08, 1, 0);
      wb(1, B + 32'h00, 1, 0);
      n = 0;
      while (hp_ctr_rst && n < 10) begin n++; @(posedge clk); end
      #1;
      for (int i = 0; i < 300; i++) begin
         r_man = 1; @(posedge clk); #1;
         r_man = 0; @(posedge clk); #1;
      end
      wait_idle(2000, n);
      wb(0, B + 32'h10, 0, 32'h0001_FF01);
      // abort in window 2 of 4
      wb(1, B + 32'h04, 8, 0);
      wb(1, B + 32'h08, 4, 0);
      wb(1, B + 32'h00, 1, 0);
      repeat (13) @(posedge clk);
      wb(1, B + 32'h00, 2, 0);
      @(negedge clk);
      check("vcc_after_abort", {31'd0, hp_vcc_en}, 32'd0);
      wb(0, B + 32'h00, 0, 32'h0);
      wb(0, B + 32'h10, 0, 32'h0001_0000);
      // NUM_WIN = 0, then start+abort together
      wb(1, B + 32'h08, 0, 0);
      vcc_hi = 0;
      wb(1, B + 32'h00, 1, 0);
      wb(0, B + 32'h00, 0, 32'h2);
      check("vcc_numwin0", vcc_hi, 0);
      wb(1, B + 32'h00, 3, 0);
      wb(0, B + 32'h00, 0, 32'h0);
      // write while busy, then reset during CLEAR
      wb(1, B + 32'h08, 2, 0);
      wb(1, B + 32'h00, 1, 0);
      wb(1, B + 32'h04, 5, 0);
      wb(0, B + 32'h00, 0, 32'h9);
      wait_idle(200, n);
      wb(0, B + 32'h04, 0, 32'h8);
      wb(1, B + 32'h00, 1, 0);
      reset = 1;
      @(negedge clk);
      check("clear_before_reset", {30'd0, hp_vcc_en, hp_ctr_rst}, 32'h3);
      @(negedge clk);
      check("outs_after_reset", {27'd0, hp_vcc_en, hp_glitch, hp_alarm_rst, hp_ctr_rst, o_wb_ack}, 32'd0);
      check("data_after_reset", o_wb_data, 32'd0);
      @(posedge clk); #1 reset = 0;
      wb(0, B + 32'h04, 0, 32'h10);
      wb(0, B + 32'h08, 0, 32'h01);
      wb(0, B + 32'h00, 0, 32'h0);
      repeat (3) @(negedge clk);
      check("ack_count", n_ack, n_acc);
      check("queue_empty", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
